// File: rtl/fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and pointer-code helpers for the async FIFO
//                write side. The helpers work on a wide fixed-width vector, so
//                callers zero-extend into ptr_wide_t and cast the result back
//                to their own pointer width.
//  Contents    : FIFO_ADDR_SIZE, PTR_W_MAX, ptr_wide_t, bin2gray, gray2bin
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_ADDR_SIZE = 3;
    localparam int PTR_W_MAX      = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_wide_t;

    function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it. Zero upper
    // bits in the input leave the lower result bits unaffected.
    function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
        ptr_wide_t bin;
        bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_ctrl_if
//  Description : Bundle of write-side control signals between a FIFO write
//                controller (slave) and the logic that drives it (master).
//  Signals     : wr_en, rptr_sync, ovf_clr          (master -> slave)
//                wptr, mem_we, mem_waddr, full,
//                almost_full, wr_level, overflow   (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = FIFO_ADDR_SIZE
);

    logic                 wr_en;
    logic [ADDR_SIZE:0]   rptr_sync;
    logic                 ovf_clr;
    logic [ADDR_SIZE:0]   wptr;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_waddr;
    logic                 full;
    logic                 almost_full;
    logic [ADDR_SIZE:0]   wr_level;
    logic                 overflow;

    modport master (
        output wr_en, rptr_sync, ovf_clr,
        input  wptr, mem_we, mem_waddr, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  wr_en, rptr_sync, ovf_clr,
        output wptr, mem_we, mem_waddr, full, almost_full, wr_level, overflow
    );

endinterface
`default_nettype wire

// File: rtl/fifo_gray_ptr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_gray_ptr
//  Description : Binary + Gray pointer pair. Both registers advance together
//                on inc; the Gray copy is loaded from the encoded next value
//                so the exported pointer comes straight off a flop and moves
//                by one bit per step.
//  Ports       : clk, rst (async, active-low), inc
//                bin / gray           - registered pointer values
//                bin_next / gray_next - values loaded on the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_gray_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = FIFO_ADDR_SIZE
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               inc,
    output logic [ADDR_SIZE:0]      bin,
    output logic [ADDR_SIZE:0]      gray,
    output logic [ADDR_SIZE:0]      bin_next,
    output logic [ADDR_SIZE:0]      gray_next
);

    localparam int PW = ADDR_SIZE + 1;

    // Natural wrap of the PW-bit add gives the modulo 2**(ADDR_SIZE+1) count.
    always_comb begin
        bin_next  = bin + {{ADDR_SIZE{1'b0}}, inc};
        gray_next = PW'(bin2gray(ptr_wide_t'(bin_next)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_ctrl
//  Description : Write-side controller of an asynchronous FIFO. Accepts
//                writes while not full, generates the RAM write strobe and
//                address, exports a Gray write pointer, and registers the
//                full / almost-full / fill-level flags against the
//                synchronized read pointer. Sticky overflow on writes while
//                full. Requires ADDR_SIZE >= 1 and 1 <= AFULL_THRESH <= 2**ADDR_SIZE.
//  Ports       : clk  - write-domain clock
//                rst  - asynchronous, active-low reset
//                bus  - fifo_wr_ctrl_if.slave (wr_en, rptr_sync, ovf_clr in;
//                       wptr, mem_we, mem_waddr, full, almost_full, wr_level,
//                       overflow out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE    = FIFO_ADDR_SIZE,
    parameter int AFULL_THRESH = 6
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fifo_wr_ctrl_if.slave   bus
);

    localparam int PW = ADDR_SIZE + 1;

    // Flipping the top two Gray bits of the read pointer gives the Gray code
    // of (read pointer + depth), i.e. the write pointer value when full.
    localparam logic [ADDR_SIZE:0] FULL_MASK = PW'(3) << (ADDR_SIZE - 1);
    localparam logic [ADDR_SIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic               accept;
    logic [ADDR_SIZE:0] wbin;
    logic [ADDR_SIZE:0] wgray;
    logic [ADDR_SIZE:0] wbin_next;
    logic [ADDR_SIZE:0] wgray_next;
    logic [ADDR_SIZE:0] rbin;
    logic [ADDR_SIZE:0] level_next;
    logic               full_next;
    logic               afull_next;
    logic               ovf_set;

    logic               full_r;
    logic               afull_r;
    logic [ADDR_SIZE:0] level_r;
    logic               ovf_r;

    fifo_gray_ptr #(
        .ADDR_SIZE (ADDR_SIZE)
    ) u_wptr (
        .clk       (clk),
        .rst       (rst),
        .inc       (accept),
        .bin       (wbin),
        .gray      (wgray),
        .bin_next  (wbin_next),
        .gray_next (wgray_next)
    );

    // The flags are computed from the registered full, so a write is never
    // accepted into the last slot twice even while rptr_sync is moving.
    always_comb begin
        accept     = bus.wr_en && !full_r;
        rbin       = PW'(gray2bin(ptr_wide_t'(bus.rptr_sync)));
        level_next = wbin_next - rbin;
        full_next  = (wgray_next == (bus.rptr_sync ^ FULL_MASK));
        afull_next = (level_next >= AFULL_LVL);
        ovf_set    = bus.wr_en && full_r;
    end

    // Flags only ever see the synchronized (lagging) read pointer, so they
    // can only be late to deassert, never early.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r  <= 1'b0;
            afull_r <= 1'b0;
            level_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            full_r  <= full_next;
            afull_r <= afull_next;
            level_r <= level_next;
            // A new overflow event wins over a same-cycle clear.
            if (ovf_set) begin
                ovf_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign bus.wptr        = wgray;
    assign bus.mem_we      = accept;
    assign bus.mem_waddr   = wbin[ADDR_SIZE-1:0];
    assign bus.full        = full_r;
    assign bus.almost_full = afull_r;
    assign bus.wr_level    = level_r;
    assign bus.overflow    = ovf_r;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_ctrl
//  Description : Self-checking bench for fifo_wr_ctrl (ADDR_SIZE=3,
//                AFULL_THRESH=6). A count-based FIFO model predicts each
//                cycle's outputs into queues; a negedge monitor pops and
//                compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

    import fifo_pkg::*;

    localparam int AS    = 3;
    localparam int AF    = 6;
    localparam int DEPTH = 1 << AS;
    localparam int PMASK = (2 * DEPTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_wr_ctrl_if #(.ADDR_SIZE(AS)) bus ();

    fifo_wr_ctrl #(
        .ADDR_SIZE    (AS),
        .AFULL_THRESH (AF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int we;
        int waddr;
        int wptr;
        int full;
        int afull;
        int level;
        int ovf;
    } exp_t;

    exp_t state_q[$];
    int   waddr_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    // Model: counts of entries written and read (mod 2*DEPTH) plus the
    // registered flag values the DUT should be showing.
    int wcnt;
    int rcnt;
    int m_level;
    int m_full;
    int m_afull;
    int m_ovf;

    function automatic int gray_of(input int b);
        return (b >> 1) ^ b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        wcnt    = 0;
        rcnt    = 0;
        m_level = 0;
        m_full  = 0;
        m_afull = 0;
        m_ovf   = 0;
        state_q.delete();
        waddr_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wptr"},      int'(bus.wptr),        0);
        check({tag, "_full"},      int'(bus.full),        0);
        check({tag, "_afull"},     int'(bus.almost_full), 0);
        check({tag, "_level"},     int'(bus.wr_level),    0);
        check({tag, "_overflow"},  int'(bus.overflow),    0);
        check({tag, "_mem_we"},    int'(bus.mem_we),      0);
        check({tag, "_mem_waddr"}, int'(bus.mem_waddr),   0);
    endtask

    // One clock of stimulus. The read side may only consume an entry that
    // has already been written.
    task automatic step(input bit wr, input bit rinc, input bit clr);
        exp_t e;
        @(posedge clk);
        #1;
        if (rinc && (((wcnt - rcnt) & PMASK) != 0)) begin
            rcnt = (rcnt + 1) & PMASK;
        end
        e.we    = (wr && (m_full == 0)) ? 1 : 0;
        e.waddr = wcnt % DEPTH;
        e.wptr  = gray_of(wcnt);
        e.full  = m_full;
        e.afull = m_afull;
        e.level = m_level;
        e.ovf   = m_ovf;
        state_q.push_back(e);
        if (e.we != 0) begin
            waddr_q.push_back(e.waddr);
        end
        bus.wr_en     = wr;
        bus.rptr_sync = (AS + 1)'(gray_of(rcnt));
        bus.ovf_clr   = clr;
        // Effect of the coming clock edge.
        if (wr && (m_full != 0)) begin
            m_ovf = 1;
        end else if (clr) begin
            m_ovf = 0;
        end
        wcnt    = (wcnt + e.we) & PMASK;
        m_level = (wcnt - rcnt) & PMASK;
        m_full  = (m_level == DEPTH) ? 1 : 0;
        m_afull = (m_level >= AF) ? 1 : 0;
    endtask

    // Asynchronous reset between clock edges; the read side resets too.
    task automatic async_reset(input string tag);
        #2;
        rst           = 1'b0;
        bus.wr_en     = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.rptr_sync = '0;
        reset_model();
        #1;
        check_zero(tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.mem_we) begin
                if (waddr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual_addr=%0d required=no_write at %0t",
                             bus.mem_waddr, $time);
                end else begin
                    check("mem_waddr", int'(bus.mem_waddr), waddr_q.pop_front());
                end
            end
            if (state_q.size() != 0) begin
                mon_e = state_q.pop_front();
                check("mem_we",      int'(bus.mem_we),      mon_e.we);
                check("wptr",        int'(bus.wptr),        mon_e.wptr);
                check("full",        int'(bus.full),        mon_e.full);
                check("almost_full", int'(bus.almost_full), mon_e.afull);
                check("wr_level",    int'(bus.wr_level),    mon_e.level);
                check("overflow",    int'(bus.overflow),    mon_e.ovf);
            end
        end
    end

    initial begin
        int bias;
        bus.wr_en     = 1'b0;
        bus.rptr_sync = '0;
        bus.ovf_clr   = 1'b0;
        reset_model();
        #12;
        check_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Fill from empty: almost_full once 6 entries are in, full at 8.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 5) check("afull_at_5", int'(bus.almost_full), 0);
            if (i == 6) check("afull_at_6", int'(bus.almost_full), 1);
        end
        step(1'b0, 1'b0, 1'b0);
        check("fill_full",  int'(bus.full),        1);
        check("fill_wptr",  int'(bus.wptr),        4'b1100);
        check("fill_level", int'(bus.wr_level),    8);
        check("fill_afull", int'(bus.almost_full), 1);

        // Overflow: set, sticky, set wins over clear, then clears.
        step(1'b1, 1'b0, 1'b0);
        check("ovf_block_we", int'(bus.mem_we), 0);
        step(1'b0, 1'b0, 1'b0);
        check("ovf_set", int'(bus.overflow), 1);
        check("ovf_wptr_hold", int'(bus.wptr), 4'b1100);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("ovf_set_beats_clr", int'(bus.overflow), 1);
        step(1'b0, 1'b0, 1'b0);
        check("ovf_cleared", int'(bus.overflow), 0);

        // One read frees a slot one clock later; the next write refills.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("read_full_drop", int'(bus.full),     0);
        check("read_level7",    int'(bus.wr_level), 7);
        step(1'b0, 1'b0, 1'b0);
        check("refill_full",    int'(bus.full),     1);

        // Randomized traffic with alternating write/read pressure.
        for (int i = 0; i < 400; i++) begin
            bias = ((i / 100) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < bias,
                 $urandom_range(0, 99) < (100 - bias),
                 $urandom_range(0, 99) < 8);
        end

        // Reset mid-burst with five entries written.
        async_reset("reset2");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        check("pre_reset_waddr", int'(bus.mem_waddr), 5);
        async_reset("reset_mid");
        step(1'b1, 1'b0, 1'b0);
        #1;
        check("post_reset_we",    int'(bus.mem_we),    1);
        check("post_reset_waddr", int'(bus.mem_waddr), 0);

        // Pointer wrap: bring both pointers to 8, then fill through the wrap.
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("wrap_wptr",  int'(bus.wptr),     0);
        check("wrap_full",  int'(bus.full),     1);
        check("wrap_level", int'(bus.wr_level), 8);

        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("state_q_drained", state_q.size(), 0);
        check("waddr_q_drained", waddr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 3, meaning FIFO depth is 2**ADDR_SIZE entries.
REQ-002 SHALL have parameter AFULL_THRESH, default 6, meaning the fill level at or above which almost_full asserts (legal range 1..2**ADDR_SIZE).
REQ-003 clk  input  1  write-domain clock, rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write request, sampled every clk.
REQ-006 rptr_sync  input  ADDR_SIZE+1  Gray-coded read pointer, already two-flop synchronized into clk domain.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 wptr  output  ADDR_SIZE+1  registered Gray-coded write pointer, exported for synchronization into the read domain.
REQ-009 mem_we  output  1  RAM write strobe.
REQ-010 mem_waddr  output  ADDR_SIZE  RAM write address.
REQ-011 full  output  1  registered full flag.
REQ-012 almost_full  output  1  registered almost-full flag.
REQ-013 wr_level  output  ADDR_SIZE+1  registered fill level, range 0..2**ADDR_SIZE.
REQ-014 overflow  output  1  sticky flag, set when a write is attempted while full.

Function
REQ-015 SHALL hold an internal binary write pointer wbin of width ADDR_SIZE+1; wptr SHALL equal gray(wbin) at all times after reset: (wbin >> 1) ^ wbin.
REQ-016 Write accepted = wr_en && !full, combinational; mem_we SHALL equal this term.
REQ-017 mem_waddr SHALL equal wbin[ADDR_SIZE-1:0], combinational.
REQ-018 On an accepted write, wbin_next = wbin + 1 modulo 2**(ADDR_SIZE+1); otherwise wbin_next = wbin.
REQ-019 full SHALL register (gray(wbin_next) == {~rptr_sync[ADDR_SIZE:ADDR_SIZE-1], rptr_sync[ADDR_SIZE-2:0]}), so it asserts on the clock edge that accepts the last free entry.
REQ-020 wr_level SHALL register wbin_next - gray2bin(rptr_sync), modulo 2**(ADDR_SIZE+1).
REQ-021 almost_full SHALL register (wbin_next - gray2bin(rptr_sync)) >= AFULL_THRESH.
REQ-022 Flags SHALL be pessimistic: after a read-side pointer change they deassert one clk after rptr_sync changes; no earlier deassertion path.
REQ-023 wr_en while full: no write and no pointer change; overflow SHALL set on the next edge.
REQ-024 overflow SHALL stay set until an edge with ovf_clr=1 and no new overflow event; a simultaneous set and clear SHALL leave it set.
REQ-025 Pointer wrap at 2**(ADDR_SIZE+1) SHALL be seamless: no flag glitch and correct level across the wrap.
REQ-026 wptr SHALL change at most one bit per clk and SHALL be driven directly from a flop, with no combinational logic after the register.

Reset
REQ-027 On rst low, asynchronously: wbin=0, wptr=0, full=0, almost_full=0, wr_level=0, overflow=0.
REQ-028 After reset deasserts, mem_we SHALL be 0 until wr_en is sampled high.
REQ-029 Reset mid-operation SHALL discard all state; the read domain is reset by the same rst, so no resync handshake is required.

Structure
REQ-030 Package fifo_pkg SHALL hold the bin2gray and gray2bin functions and the default ADDR_SIZE constant.
REQ-031 A sub-module fifo_gray_ptr SHALL hold the binary and Gray pointer registers (inputs inc and rst, outputs bin, gray, and next-state values); flags and level logic SHALL live in fifo_wr_ctrl.

Verification (ADDR_SIZE=3, AFULL_THRESH=6)
REQ-032 rptr_sync=0, 8 consecutive wr_en -> mem_waddr 0..7, then full=1 with wptr=4'b1100 and wr_level=8; almost_full=1 from the 6th write onward.
REQ-033 Full, then wr_en=1 for 1 cycle -> mem_we=0, wbin unchanged, overflow=1; overflow stays 1 until ovf_clr, and ovf_clr together with wr_en while full leaves overflow=1.
REQ-034 Full, then rptr_sync steps to gray(1)=4'b0001 -> full=0 and wr_level=7 one clk later; the next write re-asserts full.
REQ-035 Wrap: rptr_sync=4'b1100 (bin 8) with wbin=8, then 8 writes -> wbin=0, wptr=4'b0000, full=1, wr_level=8.
REQ-036 Reset asserted mid-burst (wbin=5) -> all outputs 0 immediately, without waiting for clk; the first write after reset goes to mem_waddr=0.
